// File: rtl/link_c_sched.sv
// Two-requester scheduler for the C-bus link endpoint. Each transaction runs
// arbitrate, frame copy, transmit kick, reply wait, then an ack with a result code.
module link_c_sched #(
  parameter logic [19:0] RX_TIMEOUT = 20'd100000,
  parameter logic [7:0]  TXEN_WAIT  = 8'd255,
  parameter logic [10:0] MAX_LEN    = 11'd1536
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic [1:0]  req_vld,
  input  logic [10:0] req_len_0,
  input  logic [10:0] req_len_1,
  output logic [10:0] src_raddr,
  output logic [1:0]  src_rden,
  input  logic [7:0]  src_rdata_0,
  input  logic [7:0]  src_rdata_1,
  output logic        tx_buf_wren,
  output logic [10:0] tx_buf_waddr,
  output logic [7:0]  tx_buf_wdata,
  output logic [10:0] tx_data_len,
  output logic        tx_start,
  input  logic        lb_txen,
  input  logic        o_rx_done,
  input  logic [1:0]  o_rx_crc_rslt,
  output logic [1:0]  ack,
  output logic [1:0]  rslt_code,
  output logic        grant_id,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_LOAD,
    S_KICK,
    S_TX_RISE,
    S_TX_BUSY,
    S_RX_WAIT,
    S_DONE
  } state_t;

  localparam logic [1:0] CODE_OK      = 2'b00;
  localparam logic [1:0] CODE_CRC     = 2'b01;
  localparam logic [1:0] CODE_RX_TO   = 2'b10;
  localparam logic [1:0] CODE_TX_FAIL = 2'b11;
  localparam logic [1:0] CRC_PASS     = 2'b01;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic [10:0] len_q, len_d;
  logic [10:0] addr_q, addr_d;
  logic        wr_en_q, wr_en_d;
  logic [10:0] wr_addr_q, wr_addr_d;
  logic [19:0] cnt_q, cnt_d;
  logic        rx_seen_q, rx_seen_d;
  logic [1:0]  crc_q, crc_d;
  logic [1:0]  code_q, code_d;

  logic        arb_grant;
  logic [10:0] sel_len;
  logic        rd_en;
  logic        rx_window;
  logic [19:0] cnt_inc;
  logic [1:0]  reply_crc;

  always_comb begin
    // With both requesting, the one not served last wins.
    arb_grant = (req_vld == 2'b11) ? ~last_q : req_vld[1];
    sel_len   = arb_grant ? req_len_1 : req_len_0;
    rd_en     = (state_q == S_LOAD) && (addr_q != len_q);
    rx_window = (state_q == S_TX_RISE) || (state_q == S_TX_BUSY) || (state_q == S_RX_WAIT);
    cnt_inc   = cnt_q + 20'd1;
    reply_crc = rx_seen_q ? crc_q : o_rx_crc_rslt;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    len_d     = len_q;
    addr_d    = addr_q;
    wr_en_d   = rd_en;
    wr_addr_d = rd_en ? addr_q : wr_addr_q;
    cnt_d     = cnt_q;
    rx_seen_d = rx_seen_q;
    crc_d     = crc_q;
    code_d    = code_q;

    // A reply may land while the link is still transmitting; keep it for RX_WAIT.
    if (rx_window && o_rx_done) begin
      rx_seen_d = 1'b1;
      crc_d     = o_rx_crc_rslt;
    end

    case (state_q)
      S_IDLE: begin
        if (req_vld != 2'b00) begin
          state_d = S_ARB;
        end
      end

      S_ARB: begin
        if (req_vld == 2'b00) begin
          state_d = S_IDLE;
        end else begin
          grant_d = arb_grant;
          len_d   = sel_len;
          addr_d  = '0;
          if ((sel_len == 11'd0) || (sel_len > MAX_LEN)) begin
            code_d  = CODE_TX_FAIL;
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        // The extra cycle at addr_q == len_q drains the last read into the TX buffer.
        if (addr_q != len_q) begin
          addr_d = addr_q + 11'd1;
        end else begin
          state_d = S_KICK;
        end
      end

      S_KICK: begin
        rx_seen_d = 1'b0;
        crc_d     = '0;
        cnt_d     = '0;
        addr_d    = '0;
        state_d   = S_TX_RISE;
      end

      S_TX_RISE: begin
        if (lb_txen) begin
          state_d = S_TX_BUSY;
        end else if (cnt_inc == {12'd0, TXEN_WAIT}) begin
          code_d  = CODE_TX_FAIL;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_TX_BUSY: begin
        if (!lb_txen) begin
          cnt_d   = '0;
          state_d = S_RX_WAIT;
        end
      end

      S_RX_WAIT: begin
        // A reply arriving on the timeout cycle still counts as a reply.
        if (rx_seen_q || o_rx_done) begin
          code_d  = (reply_crc == CRC_PASS) ? CODE_OK : CODE_CRC;
          state_d = S_DONE;
        end else if (cnt_inc == RX_TIMEOUT) begin
          code_d  = CODE_RX_TO;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_DONE: begin
        last_d  = grant_q;
        len_d   = '0;
        code_d  = CODE_OK;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      len_q     <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      cnt_q     <= '0;
      rx_seen_q <= 1'b0;
      crc_q     <= '0;
      code_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      cnt_q     <= cnt_d;
      rx_seen_q <= rx_seen_d;
      crc_q     <= crc_d;
      code_q    <= code_d;
    end
  end

  // Source RAM data arrives one cycle after the read, aligned with wr_en_q.
  assign src_raddr    = (state_q == S_LOAD) ? addr_q : '0;
  assign src_rden     = rd_en ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign tx_buf_wren  = wr_en_q;
  assign tx_buf_waddr = wr_en_q ? wr_addr_q : '0;
  assign tx_buf_wdata = wr_en_q ? (grant_q ? src_rdata_1 : src_rdata_0) : '0;
  assign tx_data_len  = len_q;
  assign tx_start     = (state_q == S_KICK);
  assign ack          = (state_q == S_DONE) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign rslt_code    = (state_q == S_DONE) ? code_q : 2'b00;
  assign grant_id     = grant_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_link_c_sched.sv
// Directed bench for link_c_sched: table of transactions with a simple link
// responder and source RAM model, plus hand-written arbitration and reset sequences.
module tb_link_c_sched;

  localparam logic [19:0] RXTO = 20'd300;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_vld = 2'b00;
  logic [10:0] req_len_0 = '0;
  logic [10:0] req_len_1 = '0;
  logic [10:0] src_raddr;
  logic [1:0]  src_rden;
  logic [7:0]  src_rdata_0 = '0;
  logic [7:0]  src_rdata_1 = '0;
  logic        tx_buf_wren;
  logic [10:0] tx_buf_waddr;
  logic [7:0]  tx_buf_wdata;
  logic [10:0] tx_data_len;
  logic        tx_start;
  logic        lb_txen = 1'b0;
  logic        o_rx_done = 1'b0;
  logic [1:0]  o_rx_crc_rslt = 2'b00;
  logic [1:0]  ack;
  logic [1:0]  rslt_code;
  logic        grant_id;
  logic        busy;

  link_c_sched #(
    .RX_TIMEOUT(RXTO),
    .TXEN_WAIT (8'd255),
    .MAX_LEN   (11'd1536)
  ) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .req_vld      (req_vld),
    .req_len_0    (req_len_0),
    .req_len_1    (req_len_1),
    .src_raddr    (src_raddr),
    .src_rden     (src_rden),
    .src_rdata_0  (src_rdata_0),
    .src_rdata_1  (src_rdata_1),
    .tx_buf_wren  (tx_buf_wren),
    .tx_buf_waddr (tx_buf_waddr),
    .tx_buf_wdata (tx_buf_wdata),
    .tx_data_len  (tx_data_len),
    .tx_start     (tx_start),
    .lb_txen      (lb_txen),
    .o_rx_done    (o_rx_done),
    .o_rx_crc_rslt(o_rx_crc_rslt),
    .ack          (ack),
    .rslt_code    (rslt_code),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [1:0]  req;
    logic [10:0] len0;
    logic [10:0] len1;
    int          d;        // lb_txen rise, cycles after tx_start (0 = never)
    int          l;        // lb_txen high duration
    int          rx_at;    // o_rx_done cycle after tx_start (-1 = never)
    logic [1:0]  crc;
    logic [1:0]  exp_ack;
    logic [1:0]  exp_code;
    int          exp_wr;
    int          exp_st;
    int          exp_rel;  // ack cycle after tx_start (-1 = no tx_start)
  } vec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int          wr_idx = 0;
  int          st_cnt = 0;
  logic        mon_grant = 1'b0;
  logic [10:0] mon_len = '0;

  function automatic logic [7:0] src_byte(input logic g, input logic [10:0] a);
    if (g) return 8'h50 ^ a[7:0];
    return 8'hA0 + a[7:0];
  endfunction

  function automatic logic [63:0] out_bundle();
    return 64'({src_raddr, src_rden, tx_buf_wren, tx_buf_waddr, tx_buf_wdata,
                tx_data_len, tx_start, ack, rslt_code, grant_id, busy});
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Source RAMs with one-cycle read latency.
  always @(posedge sys_clk) begin
    if (src_rden[0]) src_rdata_0 <= src_byte(1'b0, src_raddr);
    if (src_rden[1]) src_rdata_1 <= src_byte(1'b1, src_raddr);
  end

  // TX buffer writes must be sequential from 0 with the granted source bytes.
  always @(negedge sys_clk) begin
    if (rst && tx_buf_wren) begin
      check("wr_addr", 64'(tx_buf_waddr), 64'(wr_idx));
      check("wr_data", 64'(tx_buf_wdata), 64'(src_byte(mon_grant, 11'(wr_idx))));
      wr_idx++;
    end
    if (rst && tx_start) begin
      st_cnt++;
      check("tx_data_len", 64'(tx_data_len), 64'(mon_len));
    end
  end

  task automatic run_txn(input vec_t v, input string tag);
    int s;
    int r;
    int rel;
    logic got;
    logic [1:0] a;
    logic [1:0] c;
    s = -1;
    rel = -1;
    got = 1'b0;
    a = 2'b00;
    c = 2'b00;
    wr_idx = 0;
    st_cnt = 0;
    mon_grant = v.exp_ack[1];
    mon_len = v.exp_ack[1] ? v.len1 : v.len0;
    req_len_0 = v.len0;
    req_len_1 = v.len1;
    req_vld = req_vld | v.req;
    for (int n = 1; n <= 5000 && !got; n++) begin
      @(negedge sys_clk);
      if (tx_start && s < 0) s = n;
      if (ack != 2'b00) begin
        got = 1'b1;
        a = ack;
        c = rslt_code;
        if (s >= 0) rel = n - s;
        check({tag, " busy_at_ack"}, 64'(busy), 64'd1);
        req_vld = req_vld & ~ack;
        lb_txen = 1'b0;
        o_rx_done = 1'b0;
      end else if (s >= 0) begin
        r = n - s;
        lb_txen = (v.d > 0) && (r >= v.d) && (r < v.d + v.l);
        o_rx_done = (r == v.rx_at);
        o_rx_crc_rslt = v.crc;
      end
    end
    lb_txen = 1'b0;
    o_rx_done = 1'b0;
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s ack_timeout: got no ack, expected ack=%b within 5000 cycles", tag, v.exp_ack);
    end else begin
      $display("txn %s: ack=%b code=%b writes=%0d starts=%0d ack_rel=%0d", tag, a, c, wr_idx, st_cnt, rel);
      check({tag, " ack"}, 64'(a), 64'(v.exp_ack));
      check({tag, " rslt_code"}, 64'(c), 64'(v.exp_code));
      check({tag, " writes"}, 64'(wr_idx), 64'(v.exp_wr));
      check({tag, " tx_starts"}, 64'(st_cnt), 64'(v.exp_st));
      check({tag, " ack_cycle"}, 64'(rel), 64'(v.exp_rel));
    end
  endtask

  vec_t vecs[9];
  vec_t rr;
  int   k;

  initial begin
    // req, len0, len1, d, l, rx_at, crc, exp_ack, exp_code, exp_wr, exp_st, exp_rel
    vecs[0] = '{2'b01, 11'd4,    11'd0,    3, 40, 48,  2'b01, 2'b01, 2'b00, 4,    1, 49};
    vecs[1] = '{2'b01, 11'd0,    11'd0,    0, 0,  -1,  2'b01, 2'b01, 2'b11, 0,    0, -1};
    vecs[2] = '{2'b10, 11'd0,    11'd1537, 0, 0,  -1,  2'b01, 2'b10, 2'b11, 0,    0, -1};
    vecs[3] = '{2'b10, 11'd0,    11'd5,    2, 10, 15,  2'b10, 2'b10, 2'b01, 5,    1, 16};
    vecs[4] = '{2'b01, 11'd3,    11'd0,    2, 5,  -1,  2'b01, 2'b01, 2'b10, 3,    1, 308};
    vecs[5] = '{2'b10, 11'd0,    11'd2,    0, 0,  -1,  2'b01, 2'b10, 2'b11, 2,    1, 256};
    vecs[6] = '{2'b01, 11'd2,    11'd0,    2, 30, 5,   2'b01, 2'b01, 2'b00, 2,    1, 34};
    vecs[7] = '{2'b10, 11'd0,    11'd1,    1, 3,  304, 2'b01, 2'b10, 2'b00, 1,    1, 305};
    vecs[8] = '{2'b01, 11'd1536, 11'd0,    1, 2,  10,  2'b01, 2'b01, 2'b00, 1536, 1, 11};

    // Reset state.
    repeat (2) @(negedge sys_clk);
    check("reset_outputs", out_bundle(), 64'd0);
    rst = 1'b1;
    @(negedge sys_clk);
    check("idle_busy", 64'(busy), 64'd0);

    // Round robin: both from reset, requester 0 first; then 1, 0 after re-request.
    rr = '{2'b11, 11'd2, 11'd3, 2, 4, 10, 2'b01, 2'b01, 2'b00, 2, 1, 11};
    run_txn(rr, "rr_first");
    @(negedge sys_clk);
    check("rr_idle_gap_busy", 64'(busy), 64'd0);
    req_vld[0] = 1'b1;
    @(negedge sys_clk);
    check("rr_arb_busy", 64'(busy), 64'd1);
    @(negedge sys_clk);
    check("rr_grant_rden", 64'(src_rden), 64'd2);
    rr.req = 2'b00;
    rr.exp_ack = 2'b10;
    rr.exp_wr = 3;
    run_txn(rr, "rr_second");
    rr.exp_ack = 2'b01;
    rr.exp_wr = 2;
    run_txn(rr, "rr_third");

    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of LOAD, then the same request is re-served from address 0.
    wr_idx = 0;
    mon_grant = 1'b0;
    mon_len = 11'd8;
    req_len_0 = 11'd8;
    req_vld = 2'b01;
    k = 0;
    for (int n = 0; n < 50 && k < 3; n++) begin
      @(negedge sys_clk);
      if (tx_buf_wren) k++;
    end
    check("midload_reached", 64'(k), 64'd3);
    rst = 1'b0;
    #1;
    check("midload_reset_outputs", out_bundle(), 64'd0);
    repeat (2) @(negedge sys_clk);
    rst = 1'b1;
    run_txn('{2'b01, 11'd8, 11'd0, 2, 6, 12, 2'b01, 2'b01, 2'b00, 8, 1, 13}, "reserve");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 500000 ns");
    $fatal(1);
  end

endmodule

// File: doc/link_c_sched.md
Name: link_c_sched

Overview:
- Request scheduler in front of the C-bus link endpoint.
- Two local requesters share the single link TX buffer and its RX completion.
- Per transaction the block:
  - round-robin arbitrates;
  - copies the winner's frame from its source RAM into the link TX buffer;
  - pulses tx_start and tracks lb_txen;
  - waits for the reply (o_rx_done) or a timeout;
  - returns an ack pulse with a 2-bit result code.
- RX buffer readout stays with the requester; this block sequences access only.

Parameters:
- RX_TIMEOUT, 20'd100000: sys_clk cycles allowed from RX_WAIT entry to o_rx_done.
- TXEN_WAIT, 8'd255: sys_clk cycles allowed from tx_start to lb_txen rising.
- MAX_LEN, 11'd1536: largest legal frame length in bytes.

Ports:
- sys_clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- req_vld  in  2  per-requester level request; held until the matching ack bit.
- req_len_0  in  11  frame byte count, requester 0; stable while req_vld[0]=1.
- req_len_1  in  11  frame byte count, requester 1; stable while req_vld[1]=1.
- src_raddr  out  11  byte address to both source RAMs.
- src_rden  out  2  one-hot read enable to the granted source RAM.
- src_rdata_0  in  8  source RAM 0 data, 1-cycle read latency.
- src_rdata_1  in  8  source RAM 1 data, 1-cycle read latency.
- tx_buf_wren  out  1  link TX buffer write enable.
- tx_buf_waddr  out  11  link TX buffer write address.
- tx_buf_wdata  out  8  link TX buffer write data.
- tx_data_len  out  11  frame length to the link.
- tx_start  out  1  one-cycle transmit kick.
- lb_txen  in  1  link transmit-enable monitor.
- o_rx_done  in  1  link receive-complete pulse.
- o_rx_crc_rslt  in  2  link CRC result; 2'b01 = pass, any other value = fail.
- ack  out  2  one-cycle completion pulse per requester.
- rslt_code  out  2  transaction result, valid with ack.
  - 00 ok
  - 01 CRC fail
  - 10 RX timeout
  - 11 TX fault / illegal length
- grant_id  out  1  currently or last granted requester.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (rst=0): all outputs 0, FSM=IDLE, last-grant pointer=1 (requester 0 wins first), counters 0.
- Reset mid-transaction aborts immediately. No ack is issued; the requester keeps req_vld and is re-served.
- IDLE: if req_vld!=0 -> ARB next cycle.
- ARB, one cycle, round-robin:
  - if both requests are set, grant the requester not granted last; otherwise grant the sole requester;
  - latch grant_id and len = selected req_len;
  - if len==0 or len>MAX_LEN -> DONE with code 11, no link activity;
  - else -> LOAD, src_raddr=0.
- LOAD:
  - src_rden[grant]=1 on cycles where src_raddr=0..len-1; src_raddr increments each cycle.
  - One cycle after each read: tx_buf_wren=1, tx_buf_waddr=read address, tx_buf_wdata=granted src_rdata.
  - After the last write (len+1 cycles after LOAD entry) -> KICK.
- KICK, one cycle: tx_start=1; clear rx_seen flag and counters -> TX_RISE.
- tx_data_len = latched len from ARB until leaving DONE; 0 otherwise.
- TX_RISE: count cycles. lb_txen=1 -> TX_BUSY. Count reaching TXEN_WAIT -> DONE, code 11.
- TX_BUSY: wait for lb_txen=0 -> RX_WAIT. No timeout in this state; the link bounds frame length.
- rx_seen: set by o_rx_done in any state from TX_RISE through RX_WAIT, with o_rx_crc_rslt captured at the same cycle. Covers a reply overlapping the tail of TX.
- RX_WAIT:
  - rx_seen set, or o_rx_done this cycle -> DONE; code 00 if captured CRC = 01, else 01.
  - Else count cycles; count reaching RX_TIMEOUT -> DONE, code 10.
  - o_rx_done in the same cycle as the timeout: the reply wins.
- DONE, one cycle: ack[grant]=1; rslt_code is valid this cycle only and then returns to 0; update last-grant pointer -> IDLE.
- Requesters deassert req_vld the cycle after ack. The mandatory IDLE cycle guarantees a stale request is not re-granted.
- o_rx_done outside TX_RISE..RX_WAIT is ignored.
- Throughput: a back-to-back request from the other requester is granted 2 cycles after ack (IDLE, ARB).

Test Plan:
- Single request, len=4, source bytes A0..A3:
  - tx_buf writes to addresses 0..3 with data A0..A3;
  - tx_start is one pulse, tx_data_len=4;
  - lb_txen high for 40 cycles, then o_rx_done with CRC=01;
  - expect ack=01, rslt_code=00.
- Both req_vld asserted from reset:
  - requester 0 is served first, then requester 1;
  - after requester 0 re-requests while requester 1 is also requesting, the next grants alternate 1, 0.
- No reply after TX:
  - ack arrives exactly RX_TIMEOUT cycles after RX_WAIT entry, rslt_code=10.
  - Separately, o_rx_done with CRC=2'b10 gives rslt_code=01.
- Illegal and missing-TX cases:
  - req_len=0 -> ack with code 11, no tx_buf_wren and no tx_start;
  - req_len=MAX_LEN+1 -> same;
  - lb_txen held low -> code 11 after TXEN_WAIT cycles.
- Timing corner cases:
  - o_rx_done pulse while lb_txen is still high -> ack with code 00 the cycle after the RX_WAIT entry;
  - o_rx_done on the same cycle as the timeout -> code 00;
  - rst pulled low mid-LOAD -> all outputs 0 immediately, then the request is re-served from address 0.
